// File: rtl/dir_write_arbiter_pkg.sv
// rtl/dir_write_arbiter_pkg.sv - shared widths, state encodings and dir write payload type
package dir_arb_pkg;

    localparam int SET_W = 9;
    localparam int WAY_W = 3;
    localparam int TAG_W = 19;

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        BRANCH  = 2'd1,
        TRUNK   = 2'd2,
        TIP     = 2'd3
    } dir_state_e;

    typedef struct packed {
        logic            dirty;
        logic [1:0]      state;
        logic [1:0][1:0] client_states;
        logic            prefetch;
    } dir_wdata_t;

endpackage

// File: rtl/dir_write_arbiter_if.sv
// rtl/dir_write_arbiter_if.sv - requester, read and directory/tag write bundle of the write arbiter
interface dir_write_arbiter_if #(parameter int NREQ = 4);
    import dir_arb_pkg::*;

    logic                  io_rd_valid;
    logic                  io_rd_ready;
    logic [NREQ-1:0]       io_req_valid;
    logic [NREQ-1:0]       io_req_ready;
    logic [NREQ*SET_W-1:0] io_req_set;
    logic [NREQ*WAY_W-1:0] io_req_way;
    logic [NREQ-1:0]       io_req_dirty;
    logic [NREQ*2-1:0]     io_req_state;
    logic [NREQ*4-1:0]     io_req_clientStates;
    logic [NREQ-1:0]       io_req_prefetch;
    logic [NREQ-1:0]       io_req_tagWen;
    logic [NREQ*TAG_W-1:0] io_req_tag;

    logic                  io_dirWReq_valid;
    logic [SET_W-1:0]      io_dirWReq_bits_set;
    logic [WAY_W-1:0]      io_dirWReq_bits_way;
    logic                  io_dirWReq_bits_data_dirty;
    logic [1:0]            io_dirWReq_bits_data_state;
    logic [1:0]            io_dirWReq_bits_data_clientStates_0;
    logic [1:0]            io_dirWReq_bits_data_clientStates_1;
    logic                  io_dirWReq_bits_data_prefetch;
    logic                  io_tagWReq_valid;
    logic [SET_W-1:0]      io_tagWReq_bits_set;
    logic [WAY_W-1:0]      io_tagWReq_bits_way;
    logic [TAG_W-1:0]      io_tagWReq_bits_tag;
    logic                  io_conflict_err;

    modport slave (
        input  io_rd_valid, io_req_valid, io_req_set, io_req_way, io_req_dirty, io_req_state,
               io_req_clientStates, io_req_prefetch, io_req_tagWen, io_req_tag,
        output io_rd_ready, io_req_ready, io_dirWReq_valid, io_dirWReq_bits_set, io_dirWReq_bits_way,
               io_dirWReq_bits_data_dirty, io_dirWReq_bits_data_state, io_dirWReq_bits_data_clientStates_0,
               io_dirWReq_bits_data_clientStates_1, io_dirWReq_bits_data_prefetch, io_tagWReq_valid,
               io_tagWReq_bits_set, io_tagWReq_bits_way, io_tagWReq_bits_tag, io_conflict_err
    );

    modport master (
        output io_rd_valid, io_req_valid, io_req_set, io_req_way, io_req_dirty, io_req_state,
               io_req_clientStates, io_req_prefetch, io_req_tagWen, io_req_tag,
        input  io_rd_ready, io_req_ready, io_dirWReq_valid, io_dirWReq_bits_set, io_dirWReq_bits_way,
               io_dirWReq_bits_data_dirty, io_dirWReq_bits_data_state, io_dirWReq_bits_data_clientStates_0,
               io_dirWReq_bits_data_clientStates_1, io_dirWReq_bits_data_prefetch, io_tagWReq_valid,
               io_tagWReq_bits_set, io_tagWReq_bits_way, io_tagWReq_bits_tag, io_conflict_err
    );

endinterface

// File: rtl/dir_write_arbiter_rr_arbiter.sv
// rtl/dir_write_arbiter_rr_arbiter.sv - round-robin pick starting at pointer, one-hot grant plus index
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    logic [PW:0] cand;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // candidate = (pointer + k) mod N without a divider
            cand = {1'b0, pointer} + (PW+1)'(k);
            if (cand >= (PW+1)'(N))
                cand = cand - (PW+1)'(N);
            if (en && !found && req[cand[PW-1:0]]) begin
                found                  = 1'b1;
                grant[cand[PW-1:0]]    = 1'b1;
                idx                    = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/dir_write_arbiter.sv
// rtl/dir_write_arbiter.sv - dir/tag SRAM write-port arbiter; DIR_WRITE_ARB_CONFLICT_CHECK_EN adds the sticky set/way collision flag
module dir_write_arbiter
    import dir_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_STALL = 3
) (
    input  logic                clock,
    input  logic                reset,
    dir_write_arbiter_if.slave  bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(MAX_STALL + 1);

    logic [PW-1:0]    ptr_q;
    logic [SW-1:0]    stall_q;
    logic             w_pend, rd_win, wr_en;
    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    gidx;
    logic [SET_W-1:0] sel_set;
    logic [WAY_W-1:0] sel_way;
    logic [TAG_W-1:0] sel_tag;
    dir_wdata_t       sel_wdata;

    logic             dir_valid_q, tag_valid_q;
    logic [SET_W-1:0] set_q;
    logic [WAY_W-1:0] way_q;
    logic [TAG_W-1:0] tag_q;
    dir_wdata_t       wdata_q;

    // Reads win unless a write has already lost MAX_STALL times in a row.
    assign w_pend = |bus.io_req_valid;
    assign rd_win = bus.io_rd_valid && (!w_pend || (stall_q < SW'(MAX_STALL)));
    assign wr_en  = w_pend && !rd_win;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (bus.io_req_valid),
        .pointer (ptr_q),
        .en      (wr_en),
        .grant   (grant),
        .idx     (gidx)
    );

    assign bus.io_rd_ready  = rd_win;
    assign bus.io_req_ready = grant;

    always_comb begin
        sel_set                 = bus.io_req_set[int'(gidx)*SET_W +: SET_W];
        sel_way                 = bus.io_req_way[int'(gidx)*WAY_W +: WAY_W];
        sel_tag                 = bus.io_req_tag[int'(gidx)*TAG_W +: TAG_W];
        sel_wdata.dirty         = bus.io_req_dirty[gidx];
        sel_wdata.state         = bus.io_req_state[int'(gidx)*2 +: 2];
        sel_wdata.client_states = bus.io_req_clientStates[int'(gidx)*4 +: 4];
        sel_wdata.prefetch      = bus.io_req_prefetch[gidx];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            stall_q     <= '0;
            dir_valid_q <= 1'b0;
            tag_valid_q <= 1'b0;
            set_q       <= '0;
            way_q       <= '0;
            tag_q       <= '0;
            wdata_q     <= '0;
        end else begin
            dir_valid_q <= wr_en;
            tag_valid_q <= wr_en && bus.io_req_tagWen[gidx];
            if (wr_en) begin
                ptr_q   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                stall_q <= '0;
                set_q   <= sel_set;
                way_q   <= sel_way;
                tag_q   <= sel_tag;
                wdata_q <= sel_wdata;
            end else if (rd_win && w_pend && (stall_q < SW'(MAX_STALL))) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.io_dirWReq_valid                    = dir_valid_q;
    assign bus.io_dirWReq_bits_set                 = set_q;
    assign bus.io_dirWReq_bits_way                 = way_q;
    assign bus.io_dirWReq_bits_data_dirty          = wdata_q.dirty;
    assign bus.io_dirWReq_bits_data_state          = wdata_q.state;
    assign bus.io_dirWReq_bits_data_clientStates_0 = wdata_q.client_states[0];
    assign bus.io_dirWReq_bits_data_clientStates_1 = wdata_q.client_states[1];
    assign bus.io_dirWReq_bits_data_prefetch       = wdata_q.prefetch;
    assign bus.io_tagWReq_valid                    = tag_valid_q;
    assign bus.io_tagWReq_bits_set                 = set_q;
    assign bus.io_tagWReq_bits_way                 = way_q;
    assign bus.io_tagWReq_bits_tag                 = tag_q;

`ifdef DIR_WRITE_ARB_CONFLICT_CHECK_EN
    logic conflict_hit, conflict_q;

    // Pairwise requester collisions, plus a grant hitting the line being written this cycle.
    always_comb begin
        conflict_hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (bus.io_req_valid[i] && bus.io_req_valid[j] &&
                    bus.io_req_set[i*SET_W +: SET_W] == bus.io_req_set[j*SET_W +: SET_W] &&
                    bus.io_req_way[i*WAY_W +: WAY_W] == bus.io_req_way[j*WAY_W +: WAY_W])
                    conflict_hit = 1'b1;
            end
        end
        if (wr_en && dir_valid_q && sel_set == set_q && sel_way == way_q)
            conflict_hit = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            conflict_q <= 1'b0;
        else if (conflict_hit)
            conflict_q <= 1'b1;
    end

    assign bus.io_conflict_err = conflict_q;
`else
    assign bus.io_conflict_err = 1'b0;
`endif

endmodule

// File: tb/tb_dir_write_arbiter.sv
// tb/tb_dir_write_arbiter.sv - table-driven bench with payload scoreboard for dir_write_arbiter
module tb_dir_write_arbiter;

    logic clock;
    logic reset;

    dir_write_arbiter_if #(.NREQ(4)) bus ();

    dir_write_arbiter #(.NREQ(4), .MAX_STALL(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit       rst_before;
        bit       rd;
        bit [3:0] req;
        bit       exp_rd;
        bit [3:0] exp_gnt;
    } vec_t;

    typedef struct packed {
        logic [8:0]  set;
        logic [2:0]  way;
        logic        dirty;
        logic [1:0]  state;
        logic [1:0]  cs0;
        logic [1:0]  cs1;
        logic        pf;
        logic        tagwen;
        logic [18:0] tag;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    wr_t  pay[4];
    int   nvec  = 0;
    int   nfail = 0;
    bit   exp_err;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit r, bit rd, bit [3:0] req, bit erd, bit [3:0] eg);
        vec_t v;
        v.rst_before = r; v.rd = rd; v.req = req; v.exp_rd = erd; v.exp_gnt = eg;
        return v;
    endfunction

    task automatic init_payload();
        for (int i = 0; i < 4; i++) begin
            pay[i].set    = 9'h040 + 9'(i * 17);
            pay[i].way    = 3'(i);
            pay[i].dirty  = i[0];
            pay[i].state  = 2'(i);
            pay[i].cs0    = 2'(3 - i);
            pay[i].cs1    = 2'(i + 1);
            pay[i].pf     = i[1];
            pay[i].tagwen = (i != 1);
            pay[i].tag    = 19'h12340 + 19'(i);
        end
        pay[2].set    = 9'h1A5;
        pay[2].way    = 3'd5;
        pay[2].state  = 2'd3;
        pay[2].tagwen = 1'b1;
        pay[2].tag    = 19'h7FFFF;
    endtask

    task automatic drive_payload();
        for (int i = 0; i < 4; i++) begin
            bus.io_req_set[i*9 +: 9]          = pay[i].set;
            bus.io_req_way[i*3 +: 3]          = pay[i].way;
            bus.io_req_dirty[i]               = pay[i].dirty;
            bus.io_req_state[i*2 +: 2]        = pay[i].state;
            bus.io_req_clientStates[i*4 +: 4] = {pay[i].cs1, pay[i].cs0};
            bus.io_req_prefetch[i]            = pay[i].pf;
            bus.io_req_tagWen[i]              = pay[i].tagwen;
            bus.io_req_tag[i*19 +: 19]        = pay[i].tag;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.io_rd_valid  = 1'b0;
        bus.io_req_valid = '0;
        reset = 1'b1;
        #2;
        check("reset_strobes", {bus.io_dirWReq_valid, bus.io_tagWReq_valid, bus.io_conflict_err}, 0);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic apply_vec(vec_t v);
        wr_t e;
        wr_t a;
        if (v.rst_before) do_reset();
        @(negedge clock);
        bus.io_rd_valid  = v.rd;
        bus.io_req_valid = v.req;
        #1;
        check("rd_ready", bus.io_rd_ready, v.exp_rd);
        check("req_ready", bus.io_req_ready, v.exp_gnt);
        for (int i = 0; i < 4; i++)
            if (v.exp_gnt[i]) sb.push_back(pay[i]);
        @(posedge clock);
        #1;
        if (v.exp_gnt != 0) begin
            e = sb.pop_front();
            a = {bus.io_dirWReq_bits_set, bus.io_dirWReq_bits_way, bus.io_dirWReq_bits_data_dirty,
                 bus.io_dirWReq_bits_data_state, bus.io_dirWReq_bits_data_clientStates_0,
                 bus.io_dirWReq_bits_data_clientStates_1, bus.io_dirWReq_bits_data_prefetch,
                 bus.io_tagWReq_valid, bus.io_tagWReq_bits_tag};
            check("dir_strobe", bus.io_dirWReq_valid, 1);
            check("payload", a, e);
            check("tag_setway", {bus.io_tagWReq_bits_set, bus.io_tagWReq_bits_way}, {e.set, e.way});
        end else begin
            check("no_strobe", {bus.io_dirWReq_valid, bus.io_tagWReq_valid}, 0);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.io_rd_valid  = 1'b0;
        bus.io_req_valid = '0;
        init_payload();
        drive_payload();
        #12;
        check("reset_state", {bus.io_dirWReq_valid, bus.io_tagWReq_valid, bus.io_dirWReq_bits_set,
                              bus.io_tagWReq_bits_tag, bus.io_rd_ready, bus.io_req_ready, bus.io_conflict_err}, 0);
        reset = 1'b0;

        // single write from requester 2, then idle
        vecs.push_back(mk(1, 0, 4'b0100, 0, 4'b0100));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 4'b0000));
        // pointer is now 3: requester 3 goes before 0
        vecs.push_back(mk(0, 0, 4'b1001, 0, 4'b1000));
        // round-robin fairness from reset
        vecs.push_back(mk(1, 0, 4'b1111, 0, 4'b0001));
        vecs.push_back(mk(0, 0, 4'b1111, 0, 4'b0010));
        vecs.push_back(mk(0, 0, 4'b1111, 0, 4'b0100));
        vecs.push_back(mk(0, 0, 4'b1111, 0, 4'b1000));
        vecs.push_back(mk(0, 0, 4'b1111, 0, 4'b0001));
        // read starvation bound
        vecs.push_back(mk(1, 1, 4'b0010, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b0010, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b0010, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b0010, 0, 4'b0010));
        vecs.push_back(mk(0, 1, 4'b0010, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b0010, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b0010, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b0010, 0, 4'b0010));
        // reads with no writes must not advance the stall counter
        for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 4'b0000, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b1000, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b1000, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b1000, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b1000, 0, 4'b1000));
        // mixed writes, pointer wrap
        vecs.push_back(mk(0, 0, 4'b1010, 0, 4'b0010));
        vecs.push_back(mk(0, 0, 4'b1010, 0, 4'b1000));
        vecs.push_back(mk(0, 0, 4'b1001, 0, 4'b0001));
        vecs.push_back(mk(0, 0, 4'b1001, 0, 4'b1000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 4'b0000));

        foreach (vecs[i]) apply_vec(vecs[i]);
        check("sb_drained", sb.size(), 0);

        // async reset between grant and output cycle
        do_reset();
        @(negedge clock);
        bus.io_req_valid = 4'b0010;
        #1 check("ar_grant1", bus.io_req_ready, 4'b0010);
        @(posedge clock);
        #1 check("ar_strobe1", bus.io_dirWReq_valid, 1);
        @(negedge clock);
        bus.io_req_valid = 4'b1001;
        #1 check("ar_grant3", bus.io_req_ready, 4'b1000);
        reset = 1'b1;
        #1 check("ar_async_clear", {bus.io_dirWReq_valid, bus.io_tagWReq_valid}, 0);
        @(posedge clock);
        #1 check("ar_dropped", bus.io_dirWReq_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        bus.io_req_valid = 4'b1111;
        #1 check("ar_ptr_zero", bus.io_req_ready, 4'b0001);
        @(negedge clock);
        bus.io_req_valid = '0;

        // collision flag
`ifdef DIR_WRITE_ARB_CONFLICT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        pay[0].set = 9'h010; pay[0].way = 3'd2;
        pay[3].set = 9'h010; pay[3].way = 3'd2;
        drive_payload();
        @(negedge clock);
        bus.io_req_valid = 4'b1001;
        @(posedge clock);
        #1 check("conflict_set", bus.io_conflict_err, exp_err);
        @(negedge clock);
        bus.io_req_valid = '0;
        repeat (3) @(posedge clock);
        #1 check("conflict_sticky", bus.io_conflict_err, exp_err);
        do_reset();
        check("conflict_cleared", bus.io_conflict_err, 0);
        init_payload();
        drive_payload();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/dir_write_arbiter.md
Name: dir_write_arbiter

Overview:
- Shares the single-ported L2 self-directory and tag SRAM write port between NREQ MSHR requesters and one directory read requester.
- Round-robin arbitration among the writers; reads have priority, bounded by an anti-starvation counter.
- Registered outputs drive the io_dirWReq_* / io_tagWReq_* bundle consumed by the directory arrays and the dir monitor.

Parameters:
- NREQ, 4, number of MSHR write requesters (2..8).
- MAX_STALL, 3, consecutive cycles a pending write may lose to reads before a forced write grant (1..15).

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- io_rd_valid  in  1  directory read request
- io_rd_ready  out  1  read granted this cycle (combinational)
- io_req_valid  in  NREQ  per-requester write valid
- io_req_ready  out  NREQ  per-requester write grant, one-hot or zero (combinational)
- io_req_set  in  NREQ*9  set, requester i at [9i+8:9i]
- io_req_way  in  NREQ*3  way
- io_req_dirty  in  NREQ  dirty bit
- io_req_state  in  NREQ*2  self state
- io_req_clientStates  in  NREQ*4  client 0 state in bits [1:0], client 1 state in bits [3:2], per requester
- io_req_prefetch  in  NREQ  prefetch bit
- io_req_tagWen  in  NREQ  also write the tag
- io_req_tag  in  NREQ*19  tag
- io_dirWReq_valid  out  1  registered dir write strobe
- io_dirWReq_bits_set, _way, _data_dirty, _data_state, _data_clientStates_0, _data_clientStates_1, _data_prefetch  out  9/3/1/2/2/2/1  registered payload
- io_tagWReq_valid  out  1  registered tag write strobe
- io_tagWReq_bits_set, _way, _tag  out  9/3/19  registered payload
- io_conflict_err  out  1  sticky same-set/way collision flag (see Optional Feature)

Behaviour:
- Reset: all outputs and output registers 0; rr pointer = 0; stall counter = 0.
- Write pending W = |io_req_valid.
- Per-cycle decision, combinational:
  - io_rd_valid && (!W || stall_cnt < MAX_STALL): read wins. io_rd_ready = 1, io_req_ready = 0.
  - otherwise, if W: the round-robin winner gets io_req_ready[g] = 1 and io_rd_ready = 0.
  - otherwise: no grant.
- Round-robin: search starts at the pointer. After a grant to g, pointer = (g+1) mod NREQ. The pointer is unchanged when no write is granted.
- Stall counter:
  - increments (saturating at MAX_STALL) when the read wins while W = 1;
  - clears on any write grant;
  - holds when W = 0.
- Forced write: when stall_cnt == MAX_STALL, a write is granted even though the read is valid. The counter then clears.
- Accepted write at cycle t: io_dirWReq_valid = 1 at t+1 for exactly one cycle with the latched payload. io_tagWReq_valid = io_dirWReq_valid && latched tagWen, with the same set/way.
- No write at t: both valids are 0 at t+1. Payload registers hold their last value.
- There is no downstream backpressure; back-to-back grants give back-to-back write strobes.
- The handshake is a same-cycle valid/ready transfer. A requester keeps valid and payload stable until granted; the arbiter does not check this.
- Reset asserted mid-operation: outputs clear asynchronously; a write latched but not yet presented is dropped.

Optional Feature:
- Macro: DIR_WRITE_ARB_CONFLICT_CHECK_EN.
- Defined:
  - io_conflict_err is set when two or more io_req_valid bits are high in the same cycle with identical set and way.
  - It also sets when a grant targets the same set/way as the write presented on the output that cycle.
  - It is sticky until reset.
- Undefined: io_conflict_err is tied to 0 and no comparator logic is built.

Decomposition:
- Package dir_arb_pkg:
  - SET_W = 9, WAY_W = 3, TAG_W = 19;
  - state encodings INVALID = 0, BRANCH = 1, TRUNK = 2, TIP = 3;
  - a packed dir_wdata_t struct {dirty, state, clientStates[2], prefetch}.
- Sub-module rr_arbiter (parameter N): inputs req[N], pointer, en; outputs one-hot grant and the encoded index. It is instantiated once.

Test Plan:
- Single write: req 2 valid, set=0x1A5, way=5, state=TIP, tagWen=1, tag=0x7FFFF, pointer 0 → ready[2] at t. At t+1, dirWReq_valid = tagWReq_valid = 1 with that payload. Pointer becomes 3.
- Round-robin fairness: all 4 requesters held valid from reset → grant order 0, 1, 2, 3, 0. One write strobe per cycle for 5 cycles.
- Read starvation bound: io_rd_valid and req 1 held high, MAX_STALL = 3 → rd_ready for 3 cycles, then ready[1] on cycle 4. Read wins again on cycle 5.
- Read with no writes: rd_valid held for 10 cycles → rd_ready every cycle, stall_cnt stays 0, no write strobes.
- Async reset mid-flight: reset asserted between grant and the output cycle → dirWReq_valid stays 0, pointer returns to 0.
- With DIR_WRITE_ARB_CONFLICT_CHECK_EN: req 0 and req 3 both valid with set=0x010, way=2 → io_conflict_err = 1 next cycle and remains 1 until reset. Without the macro it stays 0.
